// File: rtl/pc_sequencer.sv
// pc_sequencer: boot/run/fault program counter sequencer driving an external adder
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] adder_a_o,
  output logic [31:0] adder_b_o,
  input  logic [32:0] adder_result_i,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        fault_o,
  output logic [31:0] fetch_cnt_o
);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, cnt_q, cnt_d, cnt_inc;
  logic        valid_q, valid_d, fault_q, fault_d;
  logic        unused_carry;
  assign unused_carry = adder_result_i[32];
  assign cnt_inc      = &cnt_q ? cnt_q : cnt_q + 32'd1;
  // next-state: branch beats stall beats sequential advance; FAULT holds everything
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN: begin
        if (branch_taken_i) begin
          if (branch_target_i[1:0] == 2'b00) begin
            pc_d  = branch_target_i;
            cnt_d = cnt_inc;
          end else begin
            state_d = FAULT;
            fault_d = 1'b1;
            valid_d = 1'b0;
          end
        end else if (!stall_i) begin
          pc_d  = adder_result_i[31:0];
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = FAULT;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end
  // state and registered outputs, asynchronously reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end
  assign pc_o        = pc_q;
  assign adder_a_o   = pc_q;
  assign adder_b_o   = PC_STEP;
  assign valid_o     = valid_q;
  assign fault_o     = fault_q;
  assign fetch_cnt_o = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
  logic        stall = 1'b0, br = 1'b0, amode = 1'b0, cmp_en = 1'b0;
  logic [31:0] tgt = 32'd0, alt = 32'd0;
  logic [31:0] a1, b1, pc1, cnt1, a2, b2, pc2, cnt2;
  logic        v1, f1, v2, f2;
  logic [32:0] r1, r2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign r1 = amode ? {1'b0, alt} : {1'b0, a1} + {1'b0, b1};
  assign r2 = {1'b0, a2} + {1'b0, b2};

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_taken_i(br), .branch_target_i(tgt),
    .adder_a_o(a1), .adder_b_o(b1), .adder_result_i(r1), .pc_o(pc1), .valid_o(v1),
    .fault_o(f1), .fetch_cnt_o(cnt1)
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst2_n), .stall_i(1'b0), .branch_taken_i(1'b0), .branch_target_i(32'd0),
    .adder_a_o(a2), .adder_b_o(b2), .adder_result_i(r2), .pc_o(pc2), .valid_o(v2),
    .fault_o(f2), .fetch_cnt_o(cnt2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: booted flag, fault flag, pc and saturating advance count
  logic [31:0] m_pc, m_cnt;
  logic        m_booted, m_fault;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc     <= 32'd0;
      m_cnt    <= 32'd0;
      m_booted <= 1'b0;
      m_fault  <= 1'b0;
    end else if (!m_booted) begin
      m_booted <= 1'b1;
    end else if (!m_fault) begin
      if (br) begin
        if (tgt % 4 == 0) begin
          m_pc  <= tgt;
          m_cnt <= (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
        end else m_fault <= 1'b1;
      end else if (!stall) begin
        m_pc  <= amode ? alt : m_pc + 32'd4;
        m_cnt <= (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", pc1, m_pc);
      chk("valid", {31'd0, v1}, {31'd0, m_booted && !m_fault});
      chk("fault", {31'd0, f1}, {31'd0, m_fault});
      chk("cnt", cnt1, m_cnt);
      chk("adder_a", a1, m_pc);
      chk("adder_b", b1, 32'd4);
    end
  end

  initial begin
    logic [31:0] wrap_seq [4];
    logic [31:0] rnd;
    wrap_seq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_pc", pc1, 32'd0);
    chk("rst_valid", {31'd0, v1}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("boot_valid", {31'd0, v1}, 32'd0);
    chk("boot_pc", pc1, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("seq_pc", pc1, 32'(i * 4));
      chk("seq_cnt", cnt1, 32'(i));
      chk("seq_valid", {31'd0, v1}, 32'd1);
    end
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_pc", pc1, 32'd8);
      chk("stall_cnt", cnt1, 32'd2);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_pc", pc1, 32'd12);
    chk("unstall_cnt", cnt1, 32'd3);
    stall = 1'b1; br = 1'b1; tgt = 32'h0000_0100;
    @(negedge clk);
    chk("br_pc", pc1, 32'h100);
    chk("br_cnt", cnt1, 32'd4);
    stall = 1'b0; tgt = 32'h0000_0102;
    @(negedge clk);
    chk("mis_pc", pc1, 32'h100);
    chk("mis_fault", {31'd0, f1}, 32'd1);
    chk("mis_valid", {31'd0, v1}, 32'd0);
    repeat (10) begin
      br = 1'($urandom); stall = 1'($urandom); tgt = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      chk("fault_pc", pc1, 32'h100);
      chk("fault_cnt", cnt1, 32'd4);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("clr_pc", pc1, 32'd0);
    chk("clr_fault", {31'd0, f1}, 32'd0);
    chk("clr_cnt", cnt1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; br = 1'b0; stall = 1'b0;
    @(negedge clk);
    br = 1'b1; tgt = 32'h0000_0040;
    @(negedge clk);
    chk("pc40", pc1, 32'h40);
    br = 1'b0; stall = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_pc", pc1, 32'd0);
    chk("async_valid", {31'd0, v1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
    rst2_n = 1'b1;
    #1;
    chk("wrap_boot_pc", pc2, 32'hFFFF_FFF8);
    chk("wrap_boot_valid", {31'd0, v2}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap_pc", pc2, wrap_seq[i]);
      chk("wrap_fault", {31'd0, f2}, 32'd0);
      chk("wrap_cnt", cnt2, 32'(i));
    end
    repeat (3000) begin
      @(negedge clk);
      rnd   = $urandom;
      stall = ($urandom % 4) == 0;
      br    = ($urandom % 8) == 0;
      tgt   = ($urandom % 6) == 0 ? rnd : {rnd[31:2], 2'b00};
      amode = ($urandom % 5) == 0;
      alt   = $urandom & 32'hFFFF_FFFC;
      if ($urandom % 40 == 0) begin
        #1 rst_n = 1'b0;
        #1 chk("rnd_rst_pc", pc1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
